// File: rtl/sram_bus_arbiter.sv
// Shares one sram-like master port between the instruction-fetch requester and the
// data requester. One transaction is outstanding at a time, and the grant holds from address phase to data phase.
module sram_bus_arbiter #(
  parameter int AW            = 32,
  parameter int DW            = 32,
  parameter bit DATA_PRIORITY = 1'b1
) (
  input  logic          clk,
  input  logic          resetn,
  input  logic          inst_req,
  input  logic [AW-1:0] inst_addr,
  output logic          inst_addr_ok,
  output logic          inst_data_ok,
  output logic [DW-1:0] inst_rdata,
  input  logic          data_req,
  input  logic          data_wr,
  input  logic [1:0]    data_size,
  input  logic [AW-1:0] data_addr,
  input  logic [DW-1:0] data_wdata,
  output logic          data_addr_ok,
  output logic          data_data_ok,
  output logic [DW-1:0] data_rdata,
  output logic          mem_req,
  output logic          mem_wr,
  output logic [1:0]    mem_size,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic          mem_addr_ok,
  input  logic          mem_data_ok,
  input  logic [DW-1:0] mem_rdata
);

  // Handshake: a side's address is taken in the cycle where its req and mem_addr_ok
  // are both high (addr_ok pulses then). Its response arrives as a one-cycle data_ok.
  typedef enum logic [1:0] {IDLE = 2'd0, ADDR = 2'd1, DATA = 2'd2} state_t;

  state_t state;
  logic   owner_d;       // 1 = data side owns the bus, 0 = instruction side
  logic   last_grant_d;  // 1 = data side was granted most recently

  logic sel_valid, sel_d, owner_req, drive_valid, drive_d, addr_hs, data_hs;

  always_comb begin
    sel_valid = (state == IDLE) && (inst_req || data_req);
    if (inst_req && data_req) sel_d = DATA_PRIORITY ? 1'b1 : ~last_grant_d;
    else                      sel_d = data_req;
    owner_req   = owner_d ? data_req : inst_req;
    drive_valid = sel_valid || (state == ADDR);
    drive_d     = (state == IDLE) ? sel_d : owner_d;
    addr_hs     = resetn && mem_addr_ok &&
                  (sel_valid || ((state == ADDR) && owner_req));
    data_hs     = resetn && (state == DATA) && mem_data_ok;
  end

  always_comb begin
    mem_req   = 1'b0;
    mem_wr    = 1'b0;
    mem_size  = 2'd0;
    mem_addr  = '0;
    mem_wdata = '0;
    if (resetn && drive_valid) begin
      if (drive_d) begin
        mem_req   = data_req;
        mem_wr    = data_wr;
        mem_size  = data_size;
        mem_addr  = data_addr;
        mem_wdata = data_wdata;
      end else begin
        // Fetches are always word reads.
        mem_req   = inst_req;
        mem_size  = 2'd2;
        mem_addr  = inst_addr;
      end
    end
    inst_addr_ok = addr_hs && !drive_d;
    data_addr_ok = addr_hs && drive_d;
    inst_data_ok = data_hs && !owner_d;
    data_data_ok = data_hs && owner_d;
    inst_rdata   = inst_data_ok ? mem_rdata : '0;
    data_rdata   = data_data_ok ? mem_rdata : '0;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state        <= IDLE;
      owner_d      <= 1'b0;
      last_grant_d <= 1'b1;
    end else begin
      case (state)
        IDLE: begin
          if (sel_valid) begin
            owner_d <= sel_d;
            if (mem_addr_ok) begin
              state        <= DATA;
              last_grant_d <= sel_d;
            end else begin
              state <= ADDR;
            end
          end
        end
        ADDR: begin
          // A requester dropping req before acceptance abandons the grant.
          if (!owner_req) begin
            state <= IDLE;
          end else if (mem_addr_ok) begin
            state        <= DATA;
            last_grant_d <= owner_d;
          end
        end
        DATA: begin
          if (mem_data_ok) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
